i2c_slave_byte_engine: RTL and testbench

- Target-side (slave) I2C byte engine: the responder end of the bus that the master's shift/byte logic drives.
- Oversamples SCL/SDA with the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then either receives write bytes or transmits read bytes MSB first.
- Sits between the pad open-drain buffers and a register/FIFO client.

---
 rtl/i2c_slave_byte_engine_if.sv | 27 ++
 rtl/i2c_slave_byte_engine.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_slave_byte_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_byte_engine_if.sv
// Bus and client-side signals of the I2C target byte engine.
// The slave modport is the engine's view; the master modport is the view
// of whatever drives the pads and serves the register/FIFO side.
`timescale 1ns/1ps
interface i2c_slave_byte_engine_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       rd_mode;
  logic       busy;
  logic       stop_det;
  logic       nack_det;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_load, rd_mode, busy, stop_det, nack_det
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_load, rd_mode, busy, stop_det, nack_det
  );
endinterface

// File: rtl/i2c_slave_byte_engine.sv
// I2C target byte engine: oversamples SCL/SDA, detects START/STOP,
// matches a 7-bit address and then receives or transmits bytes MSB first.
`timescale 1ns/1ps
module i2c_slave_byte_engine #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input logic                    clk,
  input logic                    asyn_rst_n,
  i2c_slave_byte_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
  } state_t;

  // Synchronisers reset to the idle-bus level so reset release makes no edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  // Byte-complete flag (write/read data) or master-ACK flag (RD_ACK).
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rd_mode_q, rd_mode_d;
  logic       busy_q, busy_d;
  logic       stop_det_q, stop_det_d;
  logic       nack_det_q, nack_det_d;
  logic       tx_load_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  // Two-flop synchroniser plus one history flop per pad.
  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_ev = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_ev  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  // Protocol state register and datapath registers.
  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rd_mode_q  <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
      nack_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_mode_q  <= rd_mode_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
      nack_det_q <= nack_det_d;
    end
  end

  // Next-state logic: START/STOP first, then per-state SCL edge handling.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_mode_d  = rd_mode_q;
    busy_d     = busy_q;
    stop_det_d = 1'b0;
    nack_det_d = 1'b0;
    tx_load_d  = 1'b0;

    if (stop_ev) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      rd_mode_d  = 1'b0;
      done_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_ev) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // shift_q[6:0] holds the address; sda_s is R/W. 0x00 never matches.
            if (shift_q[6:0] == SLAVE_ADDR && SLAVE_ADDR != 7'h00) begin
              rd_mode_d = sda_s;
              busy_d    = 1'b1;
              state_d   = S_ADDR_ACK;
            end else begin
              rd_mode_d = 1'b0;
              busy_d    = 1'b0;
              state_d   = S_IDLE;
            end
          end
        end
        // First fall starts the ACK clock, second fall ends it.
        S_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rd_mode_q) begin
            tx_load_d = 1'b1;
            shift_d   = bus.tx_data;
            sda_oe_d  = ~bus.tx_data[7];
            cnt_d     = 3'd0;
            state_d   = S_RD_DATA;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            sda_oe_d = 1'b1;
            done_d   = 1'b0;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WR_DATA;
        end
        // Shift after each bit is clocked out; the new MSB is driven on the fall.
        S_RD_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              nack_det_d = 1'b1;
              sda_oe_d   = 1'b0;
              state_d    = S_WAIT;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            tx_load_d = 1'b1;
            shift_d   = bus.tx_data;
            sda_oe_d  = ~bus.tx_data[7];
            done_d    = 1'b0;
            cnt_d     = 3'd0;
            state_d   = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_d;
  assign bus.rd_mode  = rd_mode_q;
  assign bus.busy     = busy_q;
  assign bus.stop_det = stop_det_q;
  assign bus.nack_det = nack_det_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for the I2C target byte engine: a bit-level bus master plus an
// address/byte-level reference of what the target must do.
`timescale 1ns/1ps
module tb_i2c_slave_byte_engine;

  localparam int         Q    = 8;      // clocks per quarter SCL period
  localparam logic [6:0] ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       asyn_rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_byte = 8'h00;

  int vec  = 0;
  int errs = 0;

  int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, nack_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_q[$];

  i2c_slave_byte_engine_if bus();

  // Open-drain wired-AND of master and target.
  assign bus.scl_in  = scl_m;
  assign bus.sda_in  = sda_m & ~bus.sda_oe;
  assign bus.tx_data = tx_byte;

  i2c_slave_byte_engine #(.SLAVE_ADDR(ADDR)) dut (
    .clk       (clk),
    .asyn_rst_n(asyn_rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Pulse and activity monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (asyn_rst_n) begin
      if (bus.rx_valid) begin
        rx_cnt++;
        rx_q.push_back(bus.rx_data);
      end
      if (bus.tx_load)  tx_cnt++;
      if (bus.stop_det) stop_cnt++;
      if (bus.nack_det) nack_cnt++;
      if (bus.sda_oe)   oe_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  // Reference: the ACK bit the target must put on the bus for an address.
  function automatic logic model_ack(input logic [6:0] a);
    return (a == ADDR && a != 7'h00) ? 1'b0 : 1'b1;
  endfunction

  task automatic qw(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      sda_m = 1'b1; qw();
      scl_m = 1'b1; qw();
    end
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw(2);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    qw();
    scl_m = 1'b1; qw(2);
    scl_m = 1'b0; qw();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    b = bus.sda_in;
    qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    asyn_rst_n = 1'b0;
    qw();
    obs = {bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.rd_mode,
           bus.busy, bus.stop_det, bus.nack_det, 3'b000, 1'b0};
    vec++;
    if (obs !== 19'd0) begin
      errs++; $display("FAIL reset_outputs: got %h expected %h", obs, 19'd0);
    end
    asyn_rst_n = 1'b1;
    qw();
    obs = {bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.rd_mode,
           bus.busy, bus.stop_det, bus.nack_det, 3'b000, 1'b0};
    vec++;
    if (obs !== 19'd0) begin
      errs++; $display("FAIL reset_release_idle: got %h expected %h", obs, 19'd0);
    end
  endtask

  task automatic test_write(input int n, input bit fixed);
    logic       ack;
    logic [7:0] d, got;
    int         st0 = stop_cnt;
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    vec++;
    if (ack !== model_ack(ADDR)) begin
      errs++; $display("FAIL wr_addr_ack: got %b expected %b", ack, model_ack(ADDR));
    end
    vec++;
    if ({bus.busy, bus.rd_mode} !== 2'b10) begin
      errs++; $display("FAIL wr_busy_rdmode: got %b expected 10", {bus.busy, bus.rd_mode});
    end
    for (int i = 0; i < n; i++) begin
      d = fixed ? ((i == 0) ? 8'hA5 : 8'h3C) : 8'($urandom_range(0, 255));
      write_byte(d, ack);
      vec++;
      if (ack !== 1'b0) begin
        errs++; $display("FAIL wr_data_ack: byte %0d got %b expected 0", i, ack);
      end
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      vec++;
      if (got !== d) begin
        errs++; $display("FAIL wr_rx_data: byte %0d got %h expected %h", i, got, d);
      end
    end
    bus_stop();
    vec++;
    if ({stop_cnt - st0, 30'd0, bus.busy, bus.sda_oe} !== {32'd1, 30'd0, 2'b00}) begin
      errs++; $display("FAIL wr_stop: stop_pulses %0d busy %b sda_oe %b expected 1 0 0",
                       stop_cnt - st0, bus.busy, bus.sda_oe);
    end
    $display("write n=%0d done", n);
  endtask

  task automatic test_wrong_addr(input int n);
    logic       ack;
    logic [6:0] a;
    int         oe0, rx0, st0;
    for (int i = 0; i < n; i++) begin
      if (i == 0)      a = 7'h51;
      else if (i == 1) a = 7'h00;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = a ^ 7'h01;
      end
      oe0 = oe_cnt; rx0 = rx_cnt; st0 = stop_cnt;
      bus_start();
      write_byte({a, 1'($urandom_range(0, 1))}, ack);
      vec++;
      if (ack !== model_ack(a)) begin
        errs++; $display("FAIL bad_addr_ack: addr %h got %b expected %b", a, ack, model_ack(a));
      end
      vec++;
      if (bus.busy !== 1'b0) begin
        errs++; $display("FAIL bad_addr_busy: addr %h got %b expected 0", a, bus.busy);
      end
      write_byte(8'($urandom_range(0, 255)), ack);
      bus_stop();
      vec++;
      if (oe_cnt != oe0 || rx_cnt != rx0 || stop_cnt != st0 + 1) begin
        errs++; $display("FAIL bad_addr_quiet: addr %h oe %0d rx %0d stop %0d expected 0 0 1",
                         a, oe_cnt - oe0, rx_cnt - rx0, stop_cnt - st0);
      end
      $display("wrong address %h done", a);
    end
  endtask

  task automatic test_read(input int n, input bit fixed);
    logic       ack;
    logic [7:0] bytes[$];
    logic [7:0] d;
    int         tx0 = tx_cnt, nk0 = nack_cnt;
    for (int i = 0; i < n; i++)
      bytes.push_back(fixed ? ((i == 0) ? 8'hC3 : 8'h81) : 8'($urandom_range(0, 255)));
    tx_byte = bytes[0];
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b1 : ADDR[i-1]);
    vec++;
    if (tx_cnt != tx0) begin
      errs++; $display("FAIL rd_early_load: got %0d loads expected 0", tx_cnt - tx0);
    end
    read_bit(ack);
    vec++;
    if (ack !== model_ack(ADDR) || bus.rd_mode !== 1'b1 || tx_cnt != tx0 + 1) begin
      errs++; $display("FAIL rd_addr_ack: ack %b rd_mode %b loads %0d expected 0 1 1",
                       ack, bus.rd_mode, tx_cnt - tx0);
    end
    for (int k = 0; k < n; k++) begin
      read_byte(d);
      vec++;
      if (d !== bytes[k]) begin
        errs++; $display("FAIL rd_byte: byte %0d got %h expected %h", k, d, bytes[k]);
      end
      if (k < n - 1) begin
        tx_byte = bytes[k+1];
        write_bit(1'b0);
      end else begin
        write_bit(1'b1);
      end
    end
    vec++;
    if (nack_cnt != nk0 + 1 || tx_cnt != tx0 + n || bus.sda_oe !== 1'b0) begin
      errs++; $display("FAIL rd_nack: nacks %0d loads %0d sda_oe %b expected 1 %0d 0",
                       nack_cnt - nk0, tx_cnt - tx0, bus.sda_oe, n);
    end
    bus_stop();
    vec++;
    if (bus.rd_mode !== 1'b0) begin
      errs++; $display("FAIL rd_mode_after_stop: got %b expected 0", bus.rd_mode);
    end
    $display("read n=%0d done", n);
  endtask

  task automatic test_back_to_back();
    logic       ack;
    logic [7:0] d, r, got;
    int         st0 = stop_cnt, tx0 = tx_cnt;
    d = 8'($urandom_range(0, 255));
    r = 8'($urandom_range(0, 255));
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    write_byte(d, ack);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    vec++;
    if (got !== d || bus.rd_mode !== 1'b0) begin
      errs++; $display("FAIL rs_write: data %h rd_mode %b expected %h 0", got, bus.rd_mode, d);
    end
    tx_byte = r;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b1 : ADDR[i-1]);
    read_bit(ack);
    vec++;
    if (ack !== 1'b0 || bus.rd_mode !== 1'b1 || stop_cnt != st0 || tx_cnt != tx0 + 1) begin
      errs++; $display("FAIL rs_read_addr: ack %b rd_mode %b stops %0d loads %0d expected 0 1 0 1",
                       ack, bus.rd_mode, stop_cnt - st0, tx_cnt - tx0);
    end
    read_byte(got);
    vec++;
    if (got !== r) begin
      errs++; $display("FAIL rs_read_byte: got %h expected %h", got, r);
    end
    write_bit(1'b1);
    bus_stop();
    $display("repeated start write %h read %h done", d, r);
  endtask

  task automatic test_reset_mid();
    logic       ack, b;
    logic [7:0] t;
    int         oe0, rx0, tx0, nk0, st0;
    t = 8'($urandom_range(0, 255)) & 8'hEF;   // 4th bit on the bus is 0
    tx_byte = t;
    bus_start();
    write_byte({ADDR, 1'b1}, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    vec++;
    if (bus.sda_oe !== 1'b1) begin
      errs++; $display("FAIL mid_rst_pre: sda_oe got %b expected 1", bus.sda_oe);
    end
    #2 asyn_rst_n = 1'b0;
    #1;
    vec++;
    if (bus.sda_oe !== 1'b0) begin
      errs++; $display("FAIL mid_rst_release: sda_oe got %b expected 0", bus.sda_oe);
    end
    repeat (2) @(negedge clk);
    asyn_rst_n = 1'b1;
    oe0 = oe_cnt; rx0 = rx_cnt; tx0 = tx_cnt; nk0 = nack_cnt; st0 = stop_cnt;
    qw();
    scl_m = 1'b0; qw();
    for (int i = 0; i < 12; i++) write_bit(1'($urandom_range(0, 1)));
    vec++;
    if (oe_cnt != oe0 || rx_cnt != rx0 || tx_cnt != tx0 || nack_cnt != nk0 ||
        stop_cnt != st0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL mid_rst_quiet: oe %0d rx %0d tx %0d nack %0d stop %0d busy %b expected all 0",
                       oe_cnt - oe0, rx_cnt - rx0, tx_cnt - tx0, nack_cnt - nk0,
                       stop_cnt - st0, bus.busy);
    end
    bus_stop();
    $display("reset during read bit 4 done");
  endtask

  task automatic test_stop_mid();
    logic ack;
    int   rx0, st0;
    bus_start();
    write_byte({ADDR, 1'b0}, ack);
    rx0 = rx_cnt; st0 = stop_cnt;
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    bus_stop();
    vec++;
    if (rx_cnt != rx0 || stop_cnt != st0 + 1 || bus.sda_oe !== 1'b0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL stop_mid: rx %0d stop %0d sda_oe %b busy %b expected 0 1 0 0",
                       rx_cnt - rx0, stop_cnt - st0, bus.sda_oe, bus.busy);
    end
    $display("stop after 4 write bits done");
  endtask

  initial begin
    test_reset();
    test_write(2, 1'b1);
    test_wrong_addr(4);
    test_write(3, 1'b0);
    test_read(2, 1'b1);
    test_read(3, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_stop_mid();
    test_write(2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
